// File: rtl/md_sequencer_pkg.sv
// Shared codes for the E-stage multiply/divide sequencer and its controller.
// Operation, HI/LO write, read-select and FSM state encodings.
package md_sequencer_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_NONE  = 3'b111;

    localparam logic [1:0] WR_HI   = 2'b00;
    localparam logic [1:0] WR_LO   = 2'b01;
    localparam logic [1:0] WR_NONE = 2'b11;

    localparam logic [1:0] SEL_HI = 2'b00;
    localparam logic [1:0] SEL_LO = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sequencer_calc.sv
// md_calc: combinational mult/div datapath producing {hi,lo}.
// div0 flags a zero divisor; the result is then zero and must be discarded.
module md_calc
    import md_sequencer_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [63:0] o_res,
    output logic        o_div0
);

    logic [63:0]        w_sa64;
    logic [63:0]        w_sb64;
    logic [63:0]        w_ua64;
    logic [63:0]        w_ub64;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic               w_div0;

    assign w_sa64 = {{32{i_a[31]}}, i_a};
    assign w_sb64 = {{32{i_b[31]}}, i_b};
    assign w_ua64 = {32'd0, i_a};
    assign w_ub64 = {32'd0, i_b};
    assign w_sa   = i_a;
    assign w_sb   = i_b;
    assign w_div0 = (i_b == 32'd0);
    assign o_div0 = w_div0;

    // Select the product or quotient/remainder for the requested op
    always_comb begin
        o_res = 64'd0;
        case (i_op)
            MD_MULT:  o_res = w_sa64 * w_sb64;
            MD_MULTU: o_res = w_ua64 * w_ub64;
            MD_DIV: begin
                if (!w_div0)
                    o_res = {w_sa % w_sb, w_sa / w_sb};
            end
            MD_DIVU: begin
                if (!w_div0)
                    o_res = {i_a % i_b, i_a / i_b};
            end
            default: o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div latency counter with HI/LO registers.
// Define MD_DIVZERO_FAST_EN to retire divide-by-zero without entering RUN.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  HILOOP,
    input  logic [1:0]  WHILO,
    input  logic [1:0]  HILOSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HILO_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic        r_busy;
    logic [63:0] r_pend;
    logic        r_pend_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_calc_res;
    logic        w_calc_div0;
    logic        w_start_ok;
    logic        w_launch;
    logic        w_commit;
    logic        w_wr_hi;
    logic        w_wr_lo;

    md_calc u_calc (
        .i_a    (A),
        .i_b    (B),
        .i_op   (HILOOP),
        .o_res  (w_calc_res),
        .o_div0 (w_calc_div0)
    );

`ifdef MD_DIVZERO_FAST_EN
    assign w_start_ok = start && is_md_op(HILOOP) &&
                        !(is_div_op(HILOOP) && w_calc_div0);
`else
    assign w_start_ok = start && is_md_op(HILOOP);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state: launch from IDLE, finish when the count reaches one
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_launch) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: launch, commit and direct HI/LO writes
    always_comb begin
        w_launch = 1'b0;
        w_commit = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_launch = w_start_ok;
                w_wr_hi  = !start && (WHILO == WR_HI);
                w_wr_lo  = !start && (WHILO == WR_LO);
            end
            S_RUN: w_commit = (r_cnt == CW'(1));
        endcase
    end

    // Latency counter, busy flag and captured result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_pend      <= 64'd0;
            r_pend_div0 <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            if (w_launch) begin
                r_cnt       <= is_div_op(HILOOP) ? CW'(DIV_CYCLES)
                                                 : CW'(MULT_CYCLES);
                r_pend      <= w_calc_res;
                r_pend_div0 <= w_calc_div0 && is_div_op(HILOOP);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Committed HI/LO: result at end of run, else mthi/mtlo
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!r_pend_div0) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
        end else begin
            if (w_wr_hi) r_hi <= A;
            if (w_wr_lo) r_lo <= A;
        end
    end

    // Read port shows only committed HI/LO
    always_comb begin
        HILO_out = 32'd0;
        if (HILOSel == SEL_HI)
            HILO_out = r_hi;
        else if (HILOSel == SEL_LO)
            HILO_out = r_lo;
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer.
// Expected {HI,LO} go into a scoreboard queue at start, compared at completion.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  HILOOP;
    logic [1:0]  WHILO;
    logic [1:0]  HILOSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HILO_out;

    int tests_run;
    int tests_failed;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] sb_q[$];

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .HILOOP   (HILOOP),
        .WHILO    (WHILO),
        .HILOSel  (HILOSel),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .HILO_out (HILO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int ia;
        int ib;
        longint p;
        longint unsigned up;
        int q;
        int r;
        logic [63:0] res;
        ia = a;
        ib = b;
        res = {m_hi, m_lo};
        case (op)
            MD_MULT: begin
                p = longint'(ia) * longint'(ib);
                res = p;
            end
            MD_MULTU: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                res = up;
            end
            MD_DIV: begin
                if (b != 0) begin
                    q = ia / ib;
                    r = ia % ib;
                    res = {r, q};
                end
            end
            MD_DIVU: begin
                if (b != 0) res = {a % b, a / b};
            end
            default: res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] b);
        if (op == MD_MULT || op == MD_MULTU) return 5;
`ifdef MD_DIVZERO_FAST_EN
        if (b == 0) return 0;
`endif
        return 10;
    endfunction

    task automatic check_hilo(input string nm);
        HILOSel = SEL_HI;
        #1;
        tests_run++;
        if (HILO_out !== m_hi) begin
            tests_failed++;
            $display("FAIL %s HI: got %h want %h", nm, HILO_out, m_hi);
        end
        HILOSel = SEL_LO;
        #1;
        tests_run++;
        if (HILO_out !== m_lo) begin
            tests_failed++;
            $display("FAIL %s LO: got %h want %h", nm, HILO_out, m_lo);
        end
        HILOSel = SEL_HI;
    endtask

    task automatic do_mt(input logic [1:0] wr, input logic [31:0] val);
        WHILO = wr;
        A = val;
        tick();
        WHILO = WR_NONE;
        if (wr == WR_HI) m_hi = val;
        if (wr == WR_LO) m_lo = val;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        int exp_n;
        logic [63:0] exp;
        exp_n = lat(op, b);
        sb_q.push_back(model(op, a, b));
        start = 1'b1;
        HILOOP = op;
        A = a;
        B = b;
        tick();
        start = 1'b0;
        HILOOP = MD_NONE;
        A = $urandom;
        B = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        tests_run++;
        if (n !== exp_n) begin
            tests_failed++;
            $display("FAIL %s busy cycles: got %0d want %0d", nm, n, exp_n);
        end
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: got empty want 1 entry", nm);
        end else begin
            exp = sb_q.pop_front();
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
        check_hilo(nm);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        check_hilo("reset");
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_midrun();
        do_mt(WR_HI, 32'h1111);
        do_mt(WR_LO, 32'h2222);
        start = 1'b1;
        HILOOP = MD_MULT;
        A = 32'd3;
        B = 32'd4;
        tick();
        start = 1'b0;
        HILOOP = MD_NONE;
        tick();
        reset = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun reset busy: got %b want 0", busy);
        end
        check_hilo("midrun_reset");
        reset = 1'b1;
        tick();
        run_op("after_reset", MD_MULT, 32'd3, 32'd4);
    endtask

    task automatic test_mult();
        run_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd7);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2);
    endtask

    task automatic test_div();
        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2);
        run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2);
        run_op("div_neg_div", MD_DIV, 32'd7, 32'hFFFFFFFE);
    endtask

    task automatic test_divzero();
        do_mt(WR_HI, 32'h1234);
        do_mt(WR_LO, 32'h5678);
        run_op("div0", MD_DIV, 32'd99, 32'd0);
        run_op("divu0", MD_DIVU, 32'd99, 32'd0);
    endtask

    task automatic test_simul();
        logic [63:0] exp;
        do_mt(WR_LO, 32'h5555);
        HILOSel = SEL_HI;
        WHILO = WR_HI;
        A = 32'hABCD;
        #1;
        tests_run++;
        if (HILO_out !== m_hi) begin
            tests_failed++;
            $display("FAIL mthi same-cycle: got %h want %h", HILO_out, m_hi);
        end
        tick();
        WHILO = WR_NONE;
        m_hi = 32'hABCD;
        check_hilo("mthi");
        sb_q.push_back(model(MD_MULT, 32'd2, 32'd3));
        start = 1'b1;
        HILOOP = MD_MULT;
        WHILO = WR_HI;
        A = 32'd2;
        B = 32'd3;
        tick();
        start = 1'b0;
        HILOOP = MD_NONE;
        WHILO = WR_NONE;
        repeat (4) tick();
        HILOSel = SEL_LO;
        #1;
        tests_run++;
        if (busy !== 1'b1 || HILO_out !== m_lo) begin
            tests_failed++;
            $display("FAIL commit-cycle read: got busy=%b %h want busy=1 %h",
                     busy, HILO_out, m_lo);
        end
        tick();
        exp = sb_q.pop_front();
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        tests_run++;
        if (busy !== 1'b0 || HILO_out !== 32'd6) begin
            tests_failed++;
            $display("FAIL post-commit read: got busy=%b %h want busy=0 6",
                     busy, HILO_out);
        end
        check_hilo("simul");
        HILOSel = 2'b10;
        #1;
        tests_run++;
        if (HILO_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL sel other: got %h want 0", HILO_out);
        end
        HILOSel = SEL_HI;
    endtask

    task automatic test_none();
        start = 1'b1;
        HILOOP = MD_NONE;
        WHILO = WR_LO;
        A = 32'hDEAD;
        tick();
        start = 1'b0;
        WHILO = WR_NONE;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL none op busy: got %b want 0", busy);
        end
        check_hilo("none_op");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op("b2b_mult", MD_MULT, $urandom, $urandom);
            run_op("b2b_divu", MD_DIVU, $urandom, $urandom_range(1, 1000));
            run_op("b2b_div", MD_DIV, $urandom, $urandom_range(1, 1000));
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        reset = 1'b0;
        start = 1'b0;
        HILOOP = MD_NONE;
        WHILO = WR_NONE;
        HILOSel = SEL_HI;
        A = 32'd0;
        B = 32'd0;
        test_reset();
        test_reset_midrun();
        test_mult();
        test_div();
        test_divzero();
        test_simul();
        test_none();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
